usr_sequencer: RTL and testbench
================================

USR_SEQUENCER -- requirements
Module: usr_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, register width in bits.
REQ-002 Parameter CNT_W, default 3, width of the shift-count field; maximum count is WIDTH.
REQ-003 Port clk, input, 1, single system clock; all logic SHALL be rising-edge.
REQ-004 Port clr, input, 1, synchronous active-high reset.
REQ-005 Port cmd_valid, input, 1, command present.
REQ-006 Port cmd_ready, output, 1, block can accept a command.
REQ-007 Port cmd_op, input, 2, command code: LOAD=00, SHR=01, SHL=10, ROT=11.
REQ-008 Port cmd_data, input, WIDTH, parallel word for LOAD.
REQ-009 Port cmd_count, input, CNT_W, number of shifts for SHR/SHL/ROT.
REQ-010 Port ser_in, input, 1, serial bit for SHR/SHL, sampled every shift cycle.
REQ-011 Port q, output, WIDTH, current register contents.
REQ-012 Port ser_out, output, 1, registered copy of the last bit shifted out.
REQ-013 Port busy, output, 1, command in progress.
REQ-014 Port done, output, 1, single-cycle completion pulse.

Function
REQ-015 States SHALL be IDLE, EXEC and DONE.
REQ-016 cmd_ready SHALL be 1 only in IDLE with clr low; busy SHALL be 1 in EXEC and DONE.
REQ-017 A handshake occurs when cmd_valid and cmd_ready are both 1 at a rising edge.
REQ-018 At handshake, op, data and count SHALL be latched, and the state SHALL go IDLE->EXEC.
REQ-019 cmd_valid outside IDLE SHALL be ignored, with no queuing.
REQ-020 In EXEC, the block SHALL drive the datapath select: LOAD=11, SHR=01, SHL=10, ROT=01 with serial input = q[0]; otherwise select SHALL be 00 (hold).
REQ-021 LOAD SHALL take one EXEC cycle, after which q = latched data.
REQ-022 SHR SHALL update q <= {serial, q[WIDTH-1:1]} per cycle; the bit leaving q[0] goes to ser_out.
REQ-023 SHL SHALL update q <= {q[WIDTH-2:0], serial} per cycle; the bit leaving q[WIDTH-1] goes to ser_out.
REQ-024 ROT SHALL rotate right one bit per cycle; ser_out gets the rotated bit.
REQ-025 A shift op SHALL spend exactly N EXEC cycles, where N = latched count; EXEC->DONE after the Nth shift.
REQ-026 Counts above WIDTH SHALL saturate to WIDTH.
REQ-027 Count 0 SHALL move EXEC->DONE after one cycle with select 00, leaving q and ser_out unchanged.
REQ-028 DONE SHALL last exactly one cycle with done=1, and q SHALL hold its final value; then DONE->IDLE.
REQ-029 Latency from handshake edge to done SHALL be max(N,1)+1 cycles; a new command can be accepted max(N,1)+2 cycles after the previous one.
REQ-030 ser_out and q SHALL hold their values in IDLE and DONE.

Reset
REQ-031 On clr=1 at a rising edge: state=IDLE, q=0, ser_out=0, count=0, done=0, busy=0; cmd_ready=0 while clr is high.
REQ-032 clr SHALL take priority over a simultaneous handshake; that command is dropped.
REQ-033 clr during EXEC SHALL abort the command with no done pulse.

Structure
REQ-034 Op codes, select encodings (HOLD=00, SHR=01, SHL=10, LOAD=11) and state encodings SHALL live in shared package usr_pkg.
REQ-035 The datapath SHALL be one instance of the existing universal_shift_register (ports clr, clk, left_input, right_input, parallel_input, sel, out).
REQ-036 The sequencer SHALL drive that instance's serial, parallel and select inputs and SHALL share its clr.

Verification
REQ-037 clr, then LOAD 1010 -> q=1010 two cycles after handshake, done high for one cycle, cmd_ready back next cycle.
REQ-038 From 1010, SHR count 2, ser_in=1 -> q=1101 then 1110, ser_out=0 then 1, done with q=1110.
REQ-039 From 1010, SHL count 3, ser_in=0 -> q=0100, 1000, 0000, ser_out=1, 0, 1.
REQ-040 From 1011, ROT count 4 -> q=1101, 1110, 0111, 1011; done with q=1011. Count 7 saturates to 4 shifts.
REQ-041 Count 0 -> done two cycles after handshake, q unchanged. cmd_valid held high during busy -> no second command accepted.
REQ-042 clr after two shifts of SHR count 4 -> q=0000, ser_out=0, no done, cmd_ready=1 the cycle after clr deasserts.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register sequencer.
// Op codes, datapath selects and controller states.
package usr_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROT  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'b00,
    SEL_SHR  = 2'b01,
    SEL_SHL  = 2'b10,
    SEL_LOAD = 2'b11
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left, parallel load.
// Synchronous active-high clear.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clr,
  input  logic             clk,
  input  logic             left_input,
  input  logic             right_input,
  input  logic [WIDTH-1:0] parallel_input,
  input  sel_e             sel,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (clr) begin
      out <= '0;
    end else begin
      unique case (sel)
        SEL_HOLD: out <= out;
        SEL_SHR:  out <= {left_input, out[WIDTH-1:1]};
        SEL_SHL:  out <= {out[WIDTH-2:0], right_input};
        SEL_LOAD: out <= parallel_input;
      endcase
    end
  end

endmodule

// File: rtl/usr_sequencer.sv
// Command sequencer driving a universal shift register:
// LOAD, SHR, SHL and ROT with a saturating shift count.
module usr_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

  state_e           state;
  op_e              op_r;
  logic [WIDTH-1:0] data_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_in;
  sel_e             sel;
  logic             left_in;
  logic             shift_bit;

  assign cnt_in    = (cmd_count > MAX_CNT) ? MAX_CNT : cmd_count;
  assign cmd_ready = (state == ST_IDLE) && !clr;
  assign busy      = (state != ST_IDLE);

  // Rotation is a right shift fed back from the outgoing bit
  assign left_in   = (op_r == OP_ROT) ? q[0] : ser_in;
  assign shift_bit = (op_r == OP_SHL) ? q[WIDTH-1] : q[0];

  always_comb begin
    sel = SEL_HOLD;
    if (state == ST_EXEC) begin
      if (op_r == OP_LOAD) begin
        sel = SEL_LOAD;
      end else if (cnt != '0) begin
        sel = (op_r == OP_SHL) ? SEL_SHL : SEL_SHR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= ST_IDLE;
      op_r    <= OP_LOAD;
      data_r  <= '0;
      cnt     <= '0;
      ser_out <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r   <= op_e'(cmd_op);
            data_r <= cmd_data;
            cnt    <= cnt_in;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_r == OP_LOAD || cnt == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            ser_out <= shift_bit;
            cnt     <= cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  universal_shift_register #(
    .WIDTH(WIDTH)
  ) u_usr (
    .clr           (clr),
    .clk           (clk),
    .left_input    (left_in),
    .right_input   (ser_in),
    .parallel_input(data_r),
    .sel           (sel),
    .out           (q)
  );

endmodule

// File: tb/tb_usr_sequencer.sv
// Scoreboard bench for usr_sequencer: driver predicts every shift step
// and completion; a monitor pops and compares as the DUT advances.
module tb_usr_sequencer;
  import usr_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          clr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [CW-1:0] cmd_count;
  logic          ser_in;
  logic [W-1:0]  q;
  logic          ser_out;
  logic          busy;
  logic          done;

  usr_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .clr      (clr),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .cmd_count(cmd_count),
    .ser_in   (ser_in),
    .q        (q),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           c;
    int           h;
    int           lat;
    logic [W-1:0] q;
    logic         s;
  } ev_t;

  ev_t          steps[$];
  ev_t          dones[$];
  logic [W-1:0] mq;
  logic         ms;
  int           busy_from;
  int           ready_cyc;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  bit           mon_en = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h",
               name, cyc, act, exp);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mon_en) begin
        logic eb;
        ev_t  e;
        eb = (cyc >= busy_from) && (cyc < ready_cyc);
        chk("busy", 32'(busy), 32'(eb));
        chk("cmd_ready", 32'(cmd_ready),
            32'(!clr && cyc >= ready_cyc));
        if (!eb) begin
          chk("idle_q", 32'(q), 32'(mq));
          chk("idle_ser_out", 32'(ser_out), 32'(ms));
        end
        while (steps.size() > 0 && steps[0].c < cyc) begin
          e = steps.pop_front();
          chk("step_missed", 32'(cyc), 32'(e.c));
        end
        if (steps.size() > 0 && steps[0].c == cyc) begin
          e = steps.pop_front();
          chk("step_q", 32'(q), 32'(e.q));
          chk("step_ser_out", 32'(ser_out), 32'(e.s));
        end
        while (dones.size() > 0 && dones[0].c < cyc) begin
          e = dones.pop_front();
          chk("done_missing", 32'(cyc), 32'(e.c));
        end
        if (done) begin
          if (dones.size() == 0) begin
            chk("done_spurious", 32'(done), 32'(0));
          end else begin
            e = dones.pop_front();
            chk("done_latency", 32'(cyc - e.h + 1), 32'(e.lat));
            chk("done_q", 32'(q), 32'(e.q));
          end
        end
      end
    end
  end

  // Called at a falling edge; clr is sampled at the next rising edge
  task automatic do_clr(int ncyc);
    clr       = 1'b1;
    cmd_valid = 1'b0;
    steps.delete();
    dones.delete();
    mq        = '0;
    ms        = 1'b0;
    ready_cyc = cyc + 1 + ncyc;
    busy_from = ready_cyc;
    repeat (ncyc) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic issue(logic [1:0] op, logic [W-1:0] d,
                       logic [CW-1:0] n, logic [W-1:0] bits,
                       bit hold, int abort_at);
    int           ns;
    int           m;
    int           h;
    logic [W-1:0] x;
    logic         s;
    while (cyc < ready_cyc) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = n;
    ser_in    = 1'($urandom);
    h  = cyc + 1;
    ns = (op == OP_LOAD) ? 0 : ((int'(n) > W) ? W : int'(n));
    m  = (ns == 0) ? 1 : ns;
    x  = mq;
    s  = ms;
    if (op == OP_LOAD) begin
      x = d;
      steps.push_back('{h + 1, h, 0, x, s});
    end else if (ns == 0) begin
      steps.push_back('{h + 1, h, 0, x, s});
    end else begin
      for (int k = 0; k < ns; k++) begin
        if (op == OP_SHL) begin
          s = x[W-1];
          x = W'((x << 1) | W'(bits[k]));
        end else begin
          s = x[0];
          x = (x >> 1) | (W'(op == OP_ROT ? x[0] : bits[k]) << (W - 1));
        end
        steps.push_back('{h + k + 1, h, 0, x, s});
      end
    end
    dones.push_back('{h + m, h, m + 1, x, s});
    mq        = x;
    ms        = s;
    busy_from = h;
    ready_cyc = h + m + 1;
    for (int k = 0; k < m; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        do_clr(1);
        return;
      end
      cmd_valid = hold;
      ser_in    = (k < ns) ? bits[k] : 1'($urandom);
      cmd_op    = 2'($urandom);
      cmd_data  = W'($urandom);
      cmd_count = CW'($urandom);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clr       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_data  = '0;
    cmd_count = '0;
    ser_in    = 1'b0;
    mq        = '0;
    ms        = 1'b0;
    busy_from = 0;
    ready_cyc = 1000;
    @(negedge clk);
    mon_en = 1;
    do_clr(2);

    issue(OP_LOAD, 4'b1010, 3'd0, 4'b0000, 0, -1);
    issue(OP_SHR,  4'b0000, 3'd2, 4'b1111, 0, -1);
    issue(OP_LOAD, 4'b1010, 3'd0, 4'b0000, 0, -1);
    issue(OP_SHL,  4'b0000, 3'd3, 4'b0000, 0, -1);
    issue(OP_LOAD, 4'b1011, 3'd0, 4'b0000, 0, -1);
    issue(OP_ROT,  4'b0000, 3'd4, 4'b0000, 0, -1);
    issue(OP_ROT,  4'b0000, 3'd7, 4'b0000, 0, -1);
    issue(OP_SHR,  4'b0000, 3'd0, 4'b1111, 1, -1);
    issue(OP_SHL,  4'b0000, 3'd5, 4'b0110, 1, -1);
    issue(OP_LOAD, 4'b1010, 3'd0, 4'b0000, 0, -1);
    issue(OP_SHR,  4'b0000, 3'd4, 4'b0101, 0, 2);

    for (int i = 0; i < 300; i++) begin
      logic [1:0]    op;
      logic [CW-1:0] n;
      int            ab;
      op = 2'($urandom);
      n  = CW'($urandom);
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 3)) : -1;
      if ($urandom_range(0, 39) == 0) begin
        while (cyc < ready_cyc) @(negedge clk);
        do_clr(int'($urandom_range(1, 3)));
      end
      issue(op, W'($urandom), n, W'($urandom),
            1'($urandom), ab);
    end

    while (cyc < ready_cyc + 2) @(negedge clk);
    chk("steps_drained", 32'(steps.size()), 32'(0));
    chk("dones_drained", 32'(dones.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
